pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (D->E, E->M, M->W).
//  Carries instr, PC, PC+8, N_DATA data words, dest reg and control flags downstream.
//  Adds over the fixed-field stage registers: stall (hold), flush (bubble insert) and valid tracking.
//  Bubbles never write the register file and never act as a forwarding source.
// PARAMETERS
//  DATA_W    32          width of each data word (alu result, store data, ...)
//  N_DATA    2           number of data words carried
//  REG_W     5           destination register index width
//  CTRL_W    1           control flag bits (e.g. movz condition); cleared in bubbles
//  NOP_INSTR 32'h0       instruction word driven for a bubble
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              synchronous, active-high
//  stall       in   1              hold current contents
//  flush       in   1              load a bubble this edge
//  valid_in    in   1              upstream slot holds a real instruction
//  instr_in    in   32             instruction word
//  pc_in       in   32             PC of instruction
//  pc8_in      in   32             PC+8 (jal/jalr link value)
//  data_in     in   N_DATA*DATA_W  packed data words, word k at [k*DATA_W +: DATA_W]
//  writereg_in in   REG_W          destination register
//  ctrl_in     in   CTRL_W         control flags
//  valid_out, instr_out, pc_out, pc8_out, data_out, writereg_out, ctrl_out
//              out  same widths    registered copies of the above
// BEHAVIOUR
//  - All outputs registered; latency exactly 1 clk when loading. No combinational path in->out.
//  - Priority per rising edge: reset > flush > stall > load.
//  - reset: valid_out=0, instr_out=NOP_INSTR, pc_out=0, pc8_out=0, data_out=0, writereg_out=0, ctrl_out=0.
//    Power-up (initial) values equal reset values. Reset mid-stall/flush: reset wins, stall ignored.
//  - flush (stall ignored): valid_out=0, instr_out=NOP_INSTR, data_out=0, writereg_out=0, ctrl_out=0;
//    pc_out<=pc_in, pc8_out<=pc8_in (PC kept for later exception/EPC logic).
//  - stall & !flush: every output holds its value; repeated stall cycles hold indefinitely.
//  - load, valid_in=1: all outputs <= inputs.
//  - load, valid_in=0: identical to flush (bubble propagation); writereg_out forced 0 so
//    hazard unit sees $0 and never forwards from a bubble.
//  - writereg_in=0 with valid_in=1 loads normally (valid_out=1, writereg_out=0).
//  - Two-state machine per slot, tracked by valid_out: EMPTY(0) / FULL(1).
//    EMPTY->FULL on load with valid_in=1; FULL->EMPTY on flush or load with valid_in=0;
//    stall keeps state; reset -> EMPTY.
//  - Widths fixed by parameters; no truncation or extension inside block.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: extra outputs stall_cnt[31:0], bubble_cnt[31:0].
//    stall_cnt +1 each edge with stall & !flush & !reset; bubble_cnt +1 each edge loading a
//    bubble (flush, or load with valid_in=0). Both saturate at 32'hFFFF_FFFF; both cleared by reset.
//    Counting never alters datapath behaviour.
//  PIPE_PERF_CNT_EN undefined: counter ports and logic absent; datapath identical.
// TESTING
//  1 reset=1 one edge, then release -> all outputs at reset values, valid_out=0, instr_out=NOP_INSTR.
//  2 valid_in=1, instr_in=32'h0128_4020, pc_in=32'h3000, data_in={32'h5,32'h7}, writereg_in=8
//    -> next edge outputs match exactly, valid_out=1.
//  3 load as in 2, then stall=1 for 3 edges with instr_in=32'hFFFF_FFFF
//    -> outputs stay 32'h0128_4020/3000/8; release -> new input loads next edge.
//  4 stall=1 and flush=1 same edge, pc_in=32'h3010 -> valid_out=0, instr_out=NOP_INSTR,
//    writereg_out=0, ctrl_out=0, pc_out=32'h3010.
//  5 valid_in=0 with writereg_in=31, ctrl_in=1 -> writereg_out=0, ctrl_out=0, valid_out=0.
//  6 PIPE_PERF_CNT_EN: 4 stall edges, 2 flush edges, 1 stall+flush edge -> stall_cnt=4,
//    bubble_cnt=3; reset -> both 0; preset counter at 32'hFFFF_FFFF plus stall -> stays saturated.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall (hold), flush (bubble) and valid tracking.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned N_DATA    = 2,
   parameter int unsigned REG_W     = 5,
   parameter int unsigned CTRL_W    = 1,
   parameter logic [31:0] NOP_INSTR = 32'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic [31:0]                instr_in,
   input  logic [31:0]                pc_in,
   input  logic [31:0]                pc8_in,
   input  logic [N_DATA*DATA_W-1:0]   data_in,
   input  logic [REG_W-1:0]           writereg_in,
   input  logic [CTRL_W-1:0]          ctrl_in,
`ifdef PIPE_PERF_CNT_EN
   output logic [31:0]                stall_cnt,
   output logic [31:0]                bubble_cnt,
`endif
   output logic                       valid_out,
   output logic [31:0]                instr_out,
   output logic [31:0]                pc_out,
   output logic [31:0]                pc8_out,
   output logic [N_DATA*DATA_W-1:0]   data_out,
   output logic [REG_W-1:0]           writereg_out,
   output logic [CTRL_W-1:0]          ctrl_out
);

   localparam int unsigned DW = N_DATA * DATA_W;

   typedef enum logic [0:0] {StEmpty = 1'b0, StFull = 1'b1} state_e;

   // Declaration initialisers give power-up values equal to the reset values.
   state_e              r_state    = StEmpty;
   logic [31:0]         r_instr    = NOP_INSTR;
   logic [31:0]         r_pc       = 32'h0;
   logic [31:0]         r_pc8      = 32'h0;
   logic [DW-1:0]       r_data     = '0;
   logic [REG_W-1:0]    r_writereg = '0;
   logic [CTRL_W-1:0]   r_ctrl     = '0;

   state_e              w_state_next;
   logic [31:0]         w_instr_next;
   logic [31:0]         w_pc_next;
   logic [31:0]         w_pc8_next;
   logic [DW-1:0]       w_data_next;
   logic [REG_W-1:0]    w_writereg_next;
   logic [CTRL_W-1:0]   w_ctrl_next;
   logic                w_load;
   logic                w_bubble;

   always_comb begin
      w_load          = 1'b0;
      w_bubble        = 1'b0;
      w_state_next    = r_state;
      w_instr_next    = r_instr;
      w_pc_next       = r_pc;
      w_pc8_next      = r_pc8;
      w_data_next     = r_data;
      w_writereg_next = r_writereg;
      w_ctrl_next     = r_ctrl;

      if (flush) begin
         w_bubble = 1'b1;
      end else if (!stall) begin
         w_load   = valid_in;
         w_bubble = !valid_in;
      end

      // Bubbles keep the PC for exception/EPC use but clear everything that
      // could write the register file or act as a forwarding source.
      if (w_bubble) begin
         w_state_next    = StEmpty;
         w_instr_next    = NOP_INSTR;
         w_pc_next       = pc_in;
         w_pc8_next      = pc8_in;
         w_data_next     = '0;
         w_writereg_next = '0;
         w_ctrl_next     = '0;
      end else if (w_load) begin
         w_state_next    = StFull;
         w_instr_next    = instr_in;
         w_pc_next       = pc_in;
         w_pc8_next      = pc8_in;
         w_data_next     = data_in;
         w_writereg_next = writereg_in;
         w_ctrl_next     = ctrl_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StEmpty;
         r_instr    <= NOP_INSTR;
         r_pc       <= 32'h0;
         r_pc8      <= 32'h0;
         r_data     <= '0;
         r_writereg <= '0;
         r_ctrl     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_instr    <= w_instr_next;
         r_pc       <= w_pc_next;
         r_pc8      <= w_pc8_next;
         r_data     <= w_data_next;
         r_writereg <= w_writereg_next;
         r_ctrl     <= w_ctrl_next;
      end
   end

   assign valid_out    = (r_state == StFull);
   assign instr_out    = r_instr;
   assign pc_out       = r_pc;
   assign pc8_out      = r_pc8;
   assign data_out     = r_data;
   assign writereg_out = r_writereg;
   assign ctrl_out     = r_ctrl;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_stall_cnt  = 32'h0;
   logic [31:0] r_bubble_cnt = 32'h0;
   logic        w_stall_evt;

   assign w_stall_evt = stall & ~flush;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt  <= 32'h0;
         r_bubble_cnt <= 32'h0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers counters when PIPE_PERF_CNT_EN is set.
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         stall = 1'b0;
   logic         flush = 1'b0;
   logic         valid_in = 1'b0;
   logic [31:0]  instr_in = 32'h0;
   logic [31:0]  pc_in = 32'h0;
   logic [31:0]  pc8_in = 32'h0;
   logic [63:0]  data_in = 64'h0;
   logic [4:0]   writereg_in = 5'h0;
   logic [0:0]   ctrl_in = 1'b0;
   logic         valid_out;
   logic [31:0]  instr_out;
   logic [31:0]  pc_out;
   logic [31:0]  pc8_out;
   logic [63:0]  data_out;
   logic [4:0]   writereg_out;
   logic [0:0]   ctrl_out;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]  stall_cnt;
   logic [31:0]  bubble_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   pipe_stage_reg dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .valid_in     (valid_in),
      .instr_in     (instr_in),
      .pc_in        (pc_in),
      .pc8_in       (pc8_in),
      .data_in      (data_in),
      .writereg_in  (writereg_in),
      .ctrl_in      (ctrl_in),
`ifdef PIPE_PERF_CNT_EN
      .stall_cnt    (stall_cnt),
      .bubble_cnt   (bubble_cnt),
`endif
      .valid_out    (valid_out),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .pc8_out      (pc8_out),
      .data_out     (data_out),
      .writereg_out (writereg_out),
      .ctrl_out     (ctrl_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bubble(input string tag, input logic [31:0] pc);
      check({tag, ".valid"}, 64'(valid_out), 64'h0);
      check({tag, ".instr"}, 64'(instr_out), 64'h0);
      check({tag, ".pc"}, 64'(pc_out), 64'(pc));
      check({tag, ".data"}, data_out, 64'h0);
      check({tag, ".wreg"}, 64'(writereg_out), 64'h0);
      check({tag, ".ctrl"}, 64'(ctrl_out), 64'h0);
   endtask

   initial begin
      // Reset: outputs at reset values
      instr_in = 32'hDEAD_BEEF; pc_in = 32'h1234; pc8_in = 32'h123C;
      data_in = 64'hFFFF_FFFF_FFFF_FFFF; writereg_in = 5'd3; ctrl_in = 1'b1; valid_in = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0; valid_in = 1'b0;
      check("rst.valid", 64'(valid_out), 64'h0);
      check("rst.instr", 64'(instr_out), 64'h0);
      check("rst.pc", 64'(pc_out), 64'h0);
      check("rst.pc8", 64'(pc8_out), 64'h0);
      check("rst.data", data_out, 64'h0);
      check("rst.wreg", 64'(writereg_out), 64'h0);
      check("rst.ctrl", 64'(ctrl_out), 64'h0);

      // Load a real instruction
      valid_in = 1'b1; instr_in = 32'h0128_4020; pc_in = 32'h3000; pc8_in = 32'h3008;
      data_in = {32'h5, 32'h7}; writereg_in = 5'd8; ctrl_in = 1'b1;
      step();
      check("ld.valid", 64'(valid_out), 64'h1);
      check("ld.instr", 64'(instr_out), 64'h0128_4020);
      check("ld.pc", 64'(pc_out), 64'h3000);
      check("ld.pc8", 64'(pc8_out), 64'h3008);
      check("ld.data", data_out, 64'h0000_0005_0000_0007);
      check("ld.wreg", 64'(writereg_out), 64'h8);
      check("ld.ctrl", 64'(ctrl_out), 64'h1);

      // Stall 3 edges with new inputs presented
      stall = 1'b1; instr_in = 32'hFFFF_FFFF; pc_in = 32'h4000; pc8_in = 32'h4008;
      data_in = 64'h1111_2222_3333_4444; writereg_in = 5'd9; ctrl_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stl.valid", 64'(valid_out), 64'h1);
         check("stl.instr", 64'(instr_out), 64'h0128_4020);
         check("stl.pc", 64'(pc_out), 64'h3000);
         check("stl.wreg", 64'(writereg_out), 64'h8);
         check("stl.data", data_out, 64'h0000_0005_0000_0007);
      end
      stall = 1'b0;
      step();
      check("rel.instr", 64'(instr_out), 64'hFFFF_FFFF);
      check("rel.pc", 64'(pc_out), 64'h4000);
      check("rel.data", data_out, 64'h1111_2222_3333_4444);
      check("rel.wreg", 64'(writereg_out), 64'h9);

      // Stall and flush together: flush wins, PC kept
      stall = 1'b1; flush = 1'b1; pc_in = 32'h3010; pc8_in = 32'h3018; ctrl_in = 1'b1;
      step();
      check_bubble("sfl", 32'h3010);
      check("sfl.pc8", 64'(pc8_out), 64'h3018);

      // Stall on an empty slot keeps it empty
      flush = 1'b0; pc_in = 32'h7000;
      step();
      check("stle.valid", 64'(valid_out), 64'h0);
      check("stle.pc", 64'(pc_out), 64'h3010);

      // Bubble via valid_in=0
      stall = 1'b0; valid_in = 1'b1; instr_in = 32'h2222_0000; writereg_in = 5'd12;
      step();
      check("ld2.valid", 64'(valid_out), 64'h1);
      valid_in = 1'b0; writereg_in = 5'd31; ctrl_in = 1'b1; pc_in = 32'h5000;
      step();
      check_bubble("vb", 32'h5000);

      // writereg 0 with valid loads normally
      valid_in = 1'b1; writereg_in = 5'd0; instr_in = 32'h0000_0001;
      step();
      check("wr0.valid", 64'(valid_out), 64'h1);
      check("wr0.wreg", 64'(writereg_out), 64'h0);
      check("wr0.instr", 64'(instr_out), 64'h1);

      // Reset beats stall
      stall = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0;
      check("rstl.valid", 64'(valid_out), 64'h0);
      check("rstl.instr", 64'(instr_out), 64'h0);
      check("rstl.pc", 64'(pc_out), 64'h0);

`ifdef PIPE_PERF_CNT_EN
      reset = 1'b1; valid_in = 1'b1;
      step();
      reset = 1'b0;
      check("cnt.rst0s", 64'(stall_cnt), 64'h0);
      check("cnt.rst0b", 64'(bubble_cnt), 64'h0);
      stall = 1'b1;
      repeat (4) step();
      stall = 1'b0; flush = 1'b1;
      repeat (2) step();
      stall = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0;
      step();
      check("cnt.stall", 64'(stall_cnt), 64'h4);
      check("cnt.bubble", 64'(bubble_cnt), 64'h3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("cnt.rsts", 64'(stall_cnt), 64'h0);
      check("cnt.rstb", 64'(bubble_cnt), 64'h0);
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      force dut.r_bubble_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_cnt;
      release dut.r_bubble_cnt;
      stall = 1'b1;
      step();
      stall = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("cnt.sats", 64'(stall_cnt), 64'hFFFF_FFFF);
      check("cnt.satb", 64'(bubble_cnt), 64'hFFFF_FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
